// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one external memory bus between the instruction fetch
//               requester (IF stage) and the data access requester (MEM
//               stage). Each transfer uses the active-low BACK_n handshake.
//               A transfer aborts after TIMEOUT_CYCLES wait cycles, and
//               stall is held while any request is still outstanding.
//
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               if_req/if_addr           - fetch request (held until if_ready)
//               if_rdata/if_ready        - fetch data and one-cycle done pulse
//               mem_req/mem_write/mem_size/mem_addr/mem_wdata
//                                        - data request (held until mem_ready)
//               mem_rdata/mem_ready      - raw load data and one-cycle done pulse
//               BAD/BDT_out/BDT_oe/BDT_in/BMREQ/BWRITE/BSIZE/BACK_n
//                                        - external bus pins
//               stall                    - pipeline stall
//               timeout_err              - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic [31:0] BAD,
    output logic [31:0] BDT_out,
    output logic        BDT_oe,
    input  logic [31:0] BDT_in,
    output logic        BMREQ,
    output logic        BWRITE,
    output logic [1:0]  BSIZE,
    input  logic        BACK_n,
    output logic        stall,
    output logic        timeout_err
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_IFETCH  = 2'd1;
    localparam logic [1:0] c_ST_DACCESS = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    // The abort fires on the edge that would complete the last allowed wait
    // cycle, so the counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       c_SIZE_WORD = 2'b10;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [1:0]       r_size;
    logic             r_write;
    logic [31:0]      r_if_rdata;
    logic             r_if_ready;
    logic [31:0]      r_mem_rdata;
    logic             r_mem_ready;
    logic             r_timeout_err;

    logic w_busy;
    logic w_dwrite;

    assign w_busy   = (r_state == c_ST_IFETCH) || (r_state == c_ST_DACCESS);
    assign w_dwrite = (r_state == c_ST_DACCESS) && r_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_size        <= '0;
            r_write       <= 1'b0;
            r_if_rdata    <= '0;
            r_if_ready    <= 1'b0;
            r_mem_rdata   <= '0;
            r_mem_ready   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Data access has fixed priority over instruction fetch.
                    if (mem_req) begin
                        r_state <= c_ST_DACCESS;
                        r_addr  <= mem_addr;
                        r_size  <= mem_size;
                        r_write <= mem_write;
                        r_wdata <= mem_wdata;
                    end else if (if_req) begin
                        r_state <= c_ST_IFETCH;
                        r_addr  <= if_addr;
                        r_size  <= c_SIZE_WORD;
                        r_write <= 1'b0;
                    end
                end
                c_ST_IFETCH, c_ST_DACCESS: begin
                    if (!BACK_n) begin
                        r_state <= c_ST_DONE;
                        r_cnt   <= '0;
                        if (r_state == c_ST_IFETCH) begin
                            r_if_rdata <= BDT_in;
                            r_if_ready <= 1'b1;
                        end else begin
                            // A store leaves the last load data untouched.
                            if (!r_write) begin
                                r_mem_rdata <= BDT_in;
                            end
                            r_mem_ready <= 1'b1;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state       <= c_ST_DONE;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        if (r_state == c_ST_IFETCH) begin
                            r_if_rdata <= '0;
                            r_if_ready <= 1'b1;
                        end else begin
                            r_mem_rdata <= '0;
                            r_mem_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    // No grant here: the finishing requester still holds req.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign BMREQ       = w_busy;
    assign BWRITE      = w_dwrite;
    assign BDT_oe      = w_dwrite;
    assign BAD         = r_addr;
    assign BDT_out     = r_wdata;
    assign BSIZE       = r_size;
    assign if_rdata    = r_if_rdata;
    assign if_ready    = r_if_ready;
    assign mem_rdata   = r_mem_rdata;
    assign mem_ready   = r_mem_ready;
    assign timeout_err = r_timeout_err;

    assign stall = !rst && ((if_req && !r_if_ready) || (mem_req && !r_mem_ready));

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. A table of single
//               transfers is applied in a loop, followed by directed
//               sequences for contention, timeout, reset mid-transfer and a
//               request held through its ready cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] BAD;
    logic [31:0] BDT_out;
    logic        BDT_oe;
    logic [31:0] BDT_in;
    logic        BMREQ;
    logic        BWRITE;
    logic [1:0]  BSIZE;
    logic        BACK_n;
    logic        stall;
    logic        timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(15),
        .CNT_W         (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .BAD        (BAD),
        .BDT_out    (BDT_out),
        .BDT_oe     (BDT_oe),
        .BDT_in     (BDT_in),
        .BMREQ      (BMREQ),
        .BWRITE     (BWRITE),
        .BSIZE      (BSIZE),
        .BACK_n     (BACK_n),
        .stall      (stall),
        .timeout_err(timeout_err)
    );

    typedef struct {
        bit          is_mem;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bdt;
        int          waits;
        logic [1:0]  exp_size;
        bit          exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered one step after an edge, with the DUT idle and both requests low.
    task automatic do_xfer(input vec_t v);
        BACK_n = 1'b1;
        if (v.is_mem) begin
            mem_req   = 1'b1;
            mem_write = v.wr;
            mem_size  = v.size;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
        end else begin
            if_req    = 1'b1;
            if_addr   = v.addr;
            mem_size  = v.size;
            mem_write = 1'b1;
        end
        #1;
        chk("stall_on_req", stall, 1);
        tick();
        for (int i = 0; i <= v.waits; i++) begin
            chk("bus_BMREQ", BMREQ, 1);
            chk("bus_BAD", BAD, v.addr);
            chk("bus_BSIZE", BSIZE, v.exp_size);
            chk("bus_BWRITE", BWRITE, v.exp_wr);
            chk("bus_BDT_oe", BDT_oe, v.exp_wr);
            if (v.exp_wr) chk("bus_BDT_out", BDT_out, v.wdata);
            chk("ready_early", v.is_mem ? mem_ready : if_ready, 0);
            chk("stall_busy", stall, 1);
            if (i == v.waits) begin
                BACK_n = 1'b0;
                BDT_in = v.bdt;
            end
            tick();
        end
        chk("ready_pulse", v.is_mem ? mem_ready : if_ready, 1);
        chk("rdata", v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
        chk("done_BMREQ", BMREQ, 0);
        chk("done_BDT_oe", BDT_oe, 0);
        chk("done_stall", stall, 0);
        BACK_n  = 1'b1;
        BDT_in  = $urandom;
        if_req  = 1'b0;
        mem_req = 1'b0;
        tick();
        chk("ready_drop", v.is_mem ? mem_ready : if_ready, 0);
        chk("idle_BMREQ", BMREQ, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_bus;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h0010_0093, 0, 2'b10, 1'b0, 32'h0010_0093};
        vecs[1] = '{1'b1, 1'b1, 2'b01, 32'h8000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 3, 2'b01, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 2'b00, 32'h2000_0010, 32'h5555_5555, 32'hCAFE_F00D, 1, 2'b00, 1'b0, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b1, 2'b10, 32'h0000_0004, 32'h0BAD_F00D, 32'hFFFF_FFFF, 0, 2'b10, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_A5A5, 2, 2'b10, 1'b0, 32'hA5A5_A5A5};

        rst       = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        BDT_in    = 32'h0;
        BACK_n    = 1'b0;
        tick();
        tick();
        chk("rst_BMREQ", BMREQ, 0);
        chk("rst_BWRITE", BWRITE, 0);
        chk("rst_BDT_oe", BDT_oe, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_stall", stall, 0);
        rst    = 1'b0;
        if_req = 1'b0;
        BACK_n = 1'b1;
        tick();
        chk("idle_spurious_ack_BMREQ", BMREQ, 0);

        for (int k = 0; k < 5; k++) do_xfer(vecs[k]);

        // Contention: both requests in the same cycle, BACK_n low throughout.
        BACK_n    = 1'b0;
        BDT_in    = 32'h1357_9BDF;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0200;
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_size  = 2'b10;
        mem_addr  = 32'h9000_0000;
        tick();
        chk("cont_mem_BMREQ", BMREQ, 1);
        chk("cont_mem_BAD", BAD, 32'h9000_0000);
        tick();
        chk("cont_mem_ready", mem_ready, 1);
        chk("cont_mem_rdata", mem_rdata, 32'h1357_9BDF);
        chk("cont_if_not_ready", if_ready, 0);
        chk("cont_stall_if_pending", stall, 1);
        mem_req = 1'b0;
        BDT_in  = 32'h2468_ACE0;
        tick();
        chk("cont_idle_BMREQ", BMREQ, 0);
        tick();
        chk("cont_if_BMREQ", BMREQ, 1);
        chk("cont_if_BAD", BAD, 32'h0000_0200);
        chk("cont_if_BSIZE", BSIZE, 2'b10);
        tick();
        chk("cont_if_ready", if_ready, 1);
        chk("cont_if_rdata", if_rdata, 32'h2468_ACE0);
        chk("cont_mem_ready_once", mem_ready, 0);
        if_req = 1'b0;
        BACK_n = 1'b1;
        tick();

        // Timeout: read with BACK_n stuck high.
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 32'h7000_0000;
        BDT_in    = 32'hFFFF_0000;
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("to_wait_BMREQ", BMREQ, 1);
            chk("to_wait_no_ready", mem_ready, 0);
            chk("to_wait_err_low", timeout_err, 0);
            tick();
        end
        chk("to_ready", mem_ready, 1);
        chk("to_rdata_zero", mem_rdata, 32'h0);
        chk("to_err_set", timeout_err, 1);
        chk("to_done_BMREQ", BMREQ, 0);
        mem_req = 1'b0;
        tick();
        v = '{1'b0, 1'b0, 2'b00, 32'h0000_0300, 32'h0, 32'h1111_2222, 1, 2'b10, 1'b0, 32'h1111_2222};
        do_xfer(v);
        chk("to_err_sticky", timeout_err, 1);

        // Reset during the 2nd wait cycle of a fetch.
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        BACK_n  = 1'b1;
        tick();
        chk("rstmid_BMREQ_w1", BMREQ, 1);
        tick();
        chk("rstmid_BMREQ_w2", BMREQ, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_BMREQ", BMREQ, 0);
        chk("rstmid_no_ready", if_ready, 0);
        chk("rstmid_err_clr", timeout_err, 0);
        chk("rstmid_stall", stall, 0);
        rst    = 1'b0;
        if_req = 1'b0;
        BACK_n = 1'b0;
        tick();
        chk("rstmid_after_no_ready", if_ready, 0);
        chk("rstmid_after_BMREQ", BMREQ, 0);
        BACK_n = 1'b1;
        v = '{1'b0, 1'b0, 2'b00, 32'h0000_0500, 32'h0, 32'h0BB0_0BB0, 0, 2'b10, 1'b0, 32'h0BB0_0BB0};
        do_xfer(v);

        // Held request: if_req stays high through its ready cycle.
        n_bus   = 0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0600;
        BACK_n  = 1'b0;
        BDT_in  = 32'h600D_600D;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (BMREQ) n_bus++;
            if (i == 1) begin
                chk("held_ready", if_ready, 1);
                chk("held_rdata", if_rdata, 32'h600D_600D);
            end
            if (i == 2) if_req = 1'b0;
        end
        chk("held_one_transfer", n_bus, 1);
        BACK_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
